// File: rtl/cci_mpf_svc_vtp_arbiter_pkg.sv
// Shared VTP lookup types plus the tag-table entry used by the service arbiter.
package cci_mpf_svc_vtp_arbiter_pkg;

  localparam int unsigned CCI_MPF_SHIM_VTP_MAX_SVC_REQS = 32;
  localparam int unsigned CCI_MPF_SHIM_VTP_REQ_TAG_W    = $clog2(CCI_MPF_SHIM_VTP_MAX_SVC_REQS);
  localparam int unsigned CCI_MPF_SHIM_VTP_VA_PAGE_W    = 36;
  localparam int unsigned CCI_MPF_SHIM_VTP_PA_PAGE_W    = 32;
  localparam int unsigned CCI_MPF_SVC_VTP_MAX_CLIENTS   = 8;
  localparam int unsigned CCI_MPF_SVC_VTP_CLIENT_ID_W   = $clog2(CCI_MPF_SVC_VTP_MAX_CLIENTS);

  typedef logic [CCI_MPF_SHIM_VTP_REQ_TAG_W-1:0]  t_cci_mpf_shim_vtp_req_tag;
  typedef logic [CCI_MPF_SHIM_VTP_VA_PAGE_W-1:0]  t_cci_mpf_shim_vtp_va_page;
  typedef logic [CCI_MPF_SHIM_VTP_PA_PAGE_W-1:0]  t_cci_mpf_shim_vtp_pa_page;
  typedef logic [CCI_MPF_SVC_VTP_CLIENT_ID_W-1:0] t_cci_mpf_svc_vtp_client_id;

  typedef struct packed {
    t_cci_mpf_shim_vtp_va_page pageVA;
    t_cci_mpf_shim_vtp_req_tag tag;
  } t_cci_mpf_shim_vtp_lookup_req;

  typedef struct packed {
    t_cci_mpf_shim_vtp_pa_page pagePA;
    t_cci_mpf_shim_vtp_req_tag tag;
    logic                      isBigPage;
  } t_cci_mpf_shim_vtp_lookup_rsp;

  // Per-service-tag record of who issued the lookup and under which client tag.
  typedef struct packed {
    t_cci_mpf_svc_vtp_client_id id;
    t_cci_mpf_shim_vtp_req_tag  ctag;
  } t_cci_mpf_svc_vtp_tag_entry;

endpackage

// File: rtl/cci_mpf_svc_vtp_tag_pool.sv
// Free pool of service tags: lowest-free allocation, release on response,
// outstanding count and detection of releases that hit an idle tag.
module cci_mpf_svc_vtp_tag_pool
  import cci_mpf_svc_vtp_arbiter_pkg::*;
#(
  parameter int unsigned N_TAGS = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          alloc_en_i,
  output logic                          free_any_c,
  output t_cci_mpf_shim_vtp_req_tag     alloc_tag_c,
  input  logic                          free_en_i,
  input  t_cci_mpf_shim_vtp_req_tag     free_tag_i,
  output logic                          free_hit_c,
  output logic                          spurious_c,
  output logic [$clog2(N_TAGS+1)-1:0]   count_o
);

  localparam int unsigned CNT_W = $clog2(N_TAGS + 1);
  localparam int unsigned TAG_W = $bits(t_cci_mpf_shim_vtp_req_tag);

  logic [N_TAGS-1:0] busy_q, busy_d;
  logic [N_TAGS-1:0] alloc_mask, free_mask;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              alloc_ok;

  // Lowest-index free tag wins.
  always_comb begin
    free_any_c  = 1'b0;
    alloc_tag_c = '0;
    for (int i = int'(N_TAGS) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_any_c  = 1'b1;
        alloc_tag_c = TAG_W'(i);
      end
    end
  end

  // Shifting past the top of the mask yields zero, so out-of-range tags never hit.
  assign alloc_mask = N_TAGS'(1) << alloc_tag_c;
  assign free_mask  = N_TAGS'(1) << free_tag_i;
  assign alloc_ok   = alloc_en_i & free_any_c;
  assign free_hit_c = free_en_i & (|(busy_q & free_mask));
  assign spurious_c = free_en_i & ~free_hit_c;

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (alloc_ok)   busy_d = busy_d | alloc_mask;
    if (free_hit_c) busy_d = busy_d & ~free_mask;
    count_d = count_q + CNT_W'(alloc_ok) - CNT_W'(free_hit_c);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cci_mpf_svc_vtp_arbiter.sv
// Shares one VTP translation service among N_CLIENTS shims: round-robin grant,
// service-tag remap on issue, and routing of out-of-order responses back to clients.
module cci_mpf_svc_vtp_arbiter
  import cci_mpf_svc_vtp_arbiter_pkg::*;
#(
  parameter int unsigned N_CLIENTS  = 2,
  parameter int unsigned N_SVC_TAGS = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [N_CLIENTS-1:0]              c_lookupEn,
  input  t_cci_mpf_shim_vtp_lookup_req      c_lookupReq [N_CLIENTS],
  output logic [N_CLIENTS-1:0]              c_lookupRdy,
  output logic [N_CLIENTS-1:0]              c_lookupRspValid,
  output t_cci_mpf_shim_vtp_lookup_rsp      c_lookupRsp,
  output logic                              s_lookupEn,
  output t_cci_mpf_shim_vtp_lookup_req      s_lookupReq,
  input  logic                              s_lookupRdy,
  input  logic                              s_lookupRspValid,
  input  t_cci_mpf_shim_vtp_lookup_rsp      s_lookupRsp,
  output logic [$clog2(N_SVC_TAGS+1)-1:0]   outstanding,
  output logic                              err_spurious_rsp
);

  localparam int unsigned CLI_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int unsigned SVC_IDX_W = (N_SVC_TAGS > 1) ? $clog2(N_SVC_TAGS) : 1;

  logic [CLI_W-1:0]               rr_q, rr_d;
  logic [CLI_W-1:0]               grant_idx, cand_idx;
  int unsigned                    cand;
  logic                           grant_any, can_issue, accept;

  logic                           out_valid_q, out_valid_d;
  t_cci_mpf_shim_vtp_lookup_req   out_req_q, out_req_d;

  logic [N_CLIENTS-1:0]           rsp_valid_q, rsp_valid_d;
  t_cci_mpf_shim_vtp_lookup_rsp   rsp_q, rsp_d;
  logic                           err_q, err_d;

  t_cci_mpf_svc_vtp_tag_entry     table_q [N_SVC_TAGS];
  t_cci_mpf_svc_vtp_tag_entry     new_entry, rsp_entry;

  logic                           free_any, free_hit, spurious;
  t_cci_mpf_shim_vtp_req_tag      alloc_tag;

  cci_mpf_svc_vtp_tag_pool #(
    .N_TAGS (N_SVC_TAGS)
  ) u_tag_pool (
    .clk         (clk),
    .reset_n     (reset_n),
    .alloc_en_i  (accept),
    .free_any_c  (free_any),
    .alloc_tag_c (alloc_tag),
    .free_en_i   (s_lookupRspValid),
    .free_tag_i  (s_lookupRsp.tag),
    .free_hit_c  (free_hit),
    .spurious_c  (spurious),
    .count_o     (outstanding)
  );

  // Round-robin pick: first requester at or after rr_q, modulo N_CLIENTS.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= N_CLIENTS) cand = cand - N_CLIENTS;
      cand_idx = CLI_W'(cand);
      if (!grant_any && c_lookupEn[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign can_issue   = reset_n & free_any & (~out_valid_q | s_lookupRdy);
  assign accept      = can_issue & grant_any;
  assign c_lookupRdy = accept ? (N_CLIENTS'(1) << grant_idx) : '0;
  assign s_lookupEn  = out_valid_q & s_lookupRdy;

  assign new_entry.id   = t_cci_mpf_svc_vtp_client_id'(grant_idx);
  assign new_entry.ctag = c_lookupReq[grant_idx].tag;
  assign rsp_entry      = table_q[SVC_IDX_W'(s_lookupRsp.tag)];

  always_comb begin
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_req_d   = out_req_q;
    if (s_lookupEn) out_valid_d = 1'b0;
    // A grant in the firing cycle reloads the register for back-to-back issue.
    if (accept) begin
      rr_d             = (grant_idx == CLI_W'(N_CLIENTS - 1)) ? '0 : grant_idx + CLI_W'(1);
      out_valid_d      = 1'b1;
      out_req_d.pageVA = c_lookupReq[grant_idx].pageVA;
      out_req_d.tag    = alloc_tag;
    end
  end

  // Responses for idle or out-of-range tags are dropped and flagged.
  always_comb begin
    rsp_valid_d = '0;
    rsp_d       = rsp_q;
    err_d       = err_q | spurious;
    if (free_hit) begin
      rsp_valid_d     = N_CLIENTS'(1) << rsp_entry.id;
      rsp_d.pagePA    = s_lookupRsp.pagePA;
      rsp_d.tag       = rsp_entry.ctag;
      rsp_d.isBigPage = s_lookupRsp.isBigPage;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      rsp_valid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    out_req_q <= out_req_d;
    rsp_q     <= rsp_d;
    if (accept) table_q[SVC_IDX_W'(alloc_tag)] <= new_entry;
  end

  assign s_lookupReq      = out_req_q;
  assign c_lookupRspValid = rsp_valid_q;
  assign c_lookupRsp      = rsp_q;
  assign err_spurious_rsp = err_q;

endmodule
